// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: widths, opcode encodings and the
// writeback entry carried from the ALU result stage to the register file.
package alu_pkg;

  localparam int ALU_DW = 16;
  localparam int ALU_RA = 3;

  localparam logic [3:0] OP_PASS_S = 4'b0000;
  localparam logic [3:0] OP_PASS_R = 4'b0001;
  localparam logic [3:0] OP_INC    = 4'b0010;
  localparam logic [3:0] OP_DEC    = 4'b0011;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  localparam logic [3:0] OP_SHR    = 4'b0110;
  localparam logic [3:0] OP_SHL    = 4'b0111;
  localparam logic [3:0] OP_AND    = 4'b1000;
  localparam logic [3:0] OP_OR     = 4'b1001;
  localparam logic [3:0] OP_XOR    = 4'b1010;
  localparam logic [3:0] OP_NOT    = 4'b1011;
  localparam logic [3:0] OP_NEG    = 4'b1100;

  typedef struct packed {
    logic [ALU_DW-1:0] data;
    logic [ALU_RA-1:0] dest;
    logic              reg_we;
  } wb_entry_t;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready buffer for writeback entries. The output comes straight
// from the main register; in_ready depends only on registered state.
module skid_buffer2
  import alu_pkg::*;
(
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  wb_entry_t in_entry_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output wb_entry_t out_entry_o
);

  logic      main_valid_q, main_valid_d;
  logic      skid_valid_q, skid_valid_d;
  wb_entry_t main_q, main_d;
  wb_entry_t skid_q, skid_d;
  logic      accept_s;
  logic      drain_s;

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_entry_o = main_q;
  assign accept_s    = in_valid_i & ~skid_valid_q;
  assign drain_s     = main_valid_q & out_ready_i;

  // Next-state for the empty / main-only / main+skid occupancy.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    case ({skid_valid_q, main_valid_q})
      2'b00: begin
        if (accept_s) begin
          main_valid_d = 1'b1;
          main_d       = in_entry_i;
        end else begin
          main_valid_d = 1'b0;
        end
      end
      2'b01: begin
        if (accept_s && drain_s) begin
          main_d = in_entry_i;
        end else if (drain_s) begin
          main_valid_d = 1'b0;
        end else if (accept_s) begin
          skid_valid_d = 1'b1;
          skid_d       = in_entry_i;
        end else begin
          main_valid_d = 1'b1;
        end
      end
      2'b11: begin
        if (drain_s) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          skid_valid_d = 1'b1;
        end
      end
      default: begin
        // Skid without main is unreachable; fall back to empty.
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase
  end

  // Buffer state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage after the ALU: buffers results for writeback and keeps the
// architectural N/Z/C status register plus a retired-op counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DW = ALU_DW,
  parameter int RA = ALU_RA,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_n,
  input  logic          alu_z,
  input  logic          alu_c,
  input  logic [RA-1:0] in_dest,
  input  logic          in_reg_we,
  input  logic          in_flag_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [RA-1:0] out_dest,
  output logic          out_reg_we,
  output logic          flag_n,
  output logic          flag_z,
  output logic          flag_c,
  output logic [CW-1:0] retire_cnt
);

  wb_entry_t     in_entry_s;
  wb_entry_t     out_entry_s;
  logic          accept_s;
  logic          drain_s;
  logic [2:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign in_entry_s = '{data: alu_y, dest: in_dest, reg_we: in_reg_we};

  skid_buffer2 u_skid (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_entry_i  (in_entry_s),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_entry_o (out_entry_s)
  );

  assign accept_s   = in_valid & in_ready;
  assign drain_s    = out_valid & out_ready;
  assign out_data   = out_entry_s.data;
  assign out_dest   = out_entry_s.dest;
  assign out_reg_we = out_entry_s.reg_we;
  assign flag_n     = flags_q[2];
  assign flag_z     = flags_q[1];
  assign flag_c     = flags_q[0];
  assign retire_cnt = cnt_q;

  // Flags follow accepted ops, not writeback, so stalls never delay them.
  always_comb begin
    flags_d = flags_q;
    cnt_d   = cnt_q;
    if (accept_s && in_flag_we) begin
      flags_d = {alu_n, alu_z, alu_c};
    end else begin
      flags_d = flags_q;
    end
    if (drain_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Status register and retire counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 3'b000;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
